// File: rtl/pid_calc.sv
// pid_calc: PID control output from an error triplet (e, e1, sum_e).
// One shared 16x33 signed multiplier is stepped by a small FSM. The
// accumulated result is scaled down by FRAC and clipped to OUT_MIN..OUT_MAX.
// Optional feature macro: PID_DERIV_EN.
//   Defined:   derivative term is included (latency 4, interval 5).
//   Undefined: derivative path is removed (latency 3, interval 4), and
//              kd and error1 are ignored.
module pid_calc #(
  parameter int FRAC    = 8,
  parameter int OUT_MAX = 100000,
  parameter int OUT_MIN = -100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] error,
  input  logic [31:0] error1,
  input  logic [31:0] sum_e,
  input  logic [15:0] kp,
  input  logic [15:0] ki,
  input  logic [15:0] kd,
  output logic [31:0] u,
  output logic        out_valid,
  output logic        sat
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
`ifdef PID_DERIV_EN
    MUL_D,
`endif
    SAT
  } state_t;

  // Output limits widened to the accumulator width so the clip compare is
  // done on the full shifted value, not on a truncated copy.
  localparam logic signed [51:0] OUT_MAX_X = 52'(OUT_MAX);
  localparam logic signed [51:0] OUT_MIN_X = 52'(OUT_MIN);

  state_t state_reg, state_next;

  logic signed [31:0] e_reg;
  logic signed [31:0] sum_reg;
  logic signed [15:0] kp_reg;
  logic signed [15:0] ki_reg;
  logic signed [51:0] acc_reg;
  logic [31:0]        u_reg;
  logic               sat_reg;
  logic               out_valid_reg;

  logic               accept;
  logic signed [15:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [48:0] product;
  logic signed [51:0] product_x;
  logic signed [51:0] y;

`ifdef PID_DERIV_EN
  logic signed [31:0] e1_reg;
  logic signed [15:0] kd_reg;
  logic signed [32:0] diff;

  // Difference is formed at 33 bits so extreme errors never wrap.
  assign diff = {e_reg[31], e_reg} - {e1_reg[31], e1_reg};
`else
  // kd and error1 are part of the interface but carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{kd, error1};
`endif

  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;

  // Operand select for the single shared multiplier, keyed by state.
  always_comb begin
    mul_a = kp_reg;
    mul_b = {e_reg[31], e_reg};
    case (state_reg)
      MUL_I: begin
        mul_a = ki_reg;
        mul_b = {sum_reg[31], sum_reg};
      end
`ifdef PID_DERIV_EN
      MUL_D: begin
        mul_a = kd_reg;
        mul_b = diff;
      end
`endif
      default: ;
    endcase
  end

  assign product   = 49'(mul_a) * 49'(mul_b);
  assign product_x = {{3{product[48]}}, product};
  assign y         = acc_reg >>> FRAC;

  // Next-state sequencing of the multiply steps.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = MUL_P;
      MUL_P: state_next = MUL_I;
`ifdef PID_DERIV_EN
      MUL_I: state_next = MUL_D;
      MUL_D: state_next = SAT;
`else
      MUL_I: state_next = SAT;
`endif
      SAT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Input capture, accumulation and the saturating output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_reg         <= '0;
      sum_reg       <= '0;
      kp_reg        <= '0;
      ki_reg        <= '0;
`ifdef PID_DERIV_EN
      e1_reg        <= '0;
      kd_reg        <= '0;
`endif
      acc_reg       <= '0;
      u_reg         <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            e_reg   <= error;
            sum_reg <= sum_e;
            kp_reg  <= kp;
            ki_reg  <= ki;
`ifdef PID_DERIV_EN
            e1_reg  <= error1;
            kd_reg  <= kd;
`endif
            acc_reg <= '0;
          end
        end
        MUL_P: acc_reg <= product_x;
        MUL_I: acc_reg <= acc_reg + product_x;
`ifdef PID_DERIV_EN
        MUL_D: acc_reg <= acc_reg + product_x;
`endif
        SAT: begin
          if (y > OUT_MAX_X) begin
            u_reg   <= OUT_MAX_X[31:0];
            sat_reg <= 1'b1;
          end else if (y < OUT_MIN_X) begin
            u_reg   <= OUT_MIN_X[31:0];
            sat_reg <= 1'b1;
          end else begin
            u_reg   <= y[31:0];
            sat_reg <= 1'b0;
          end
          out_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign u         = u_reg;
  assign sat       = sat_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_pid_calc.sv
// tb_pid_calc: directed and randomized checks of pid_calc against a
// plain-arithmetic reference model of the PID equation.
module tb_pid_calc;

  localparam int FRAC    = 8;
  localparam int OUT_MAX = 100000;
  localparam int OUT_MIN = -100000;
`ifdef PID_DERIV_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] error = '0;
  logic signed [31:0] error1 = '0;
  logic signed [31:0] sum_e = '0;
  logic signed [15:0] kp = '0;
  logic signed [15:0] ki = '0;
  logic signed [15:0] kd = '0;
  logic [31:0]        u;
  logic               out_valid;
  logic               sat;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint u;
    longint s;
  } exp_t;

  exp_t exp_q[$];

  pid_calc #(.FRAC(FRAC), .OUT_MAX(OUT_MAX), .OUT_MIN(OUT_MIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .error(error), .error1(error1), .sum_e(sum_e),
    .kp(kp), .ki(ki), .kd(kd),
    .u(u), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: u = clip(floor((kp*e + ki*sum + kd*(e-e1)) / 2^FRAC)).
  function automatic exp_t model(input logic signed [15:0] gp, input logic signed [15:0] gi_,
                                 input logic signed [15:0] gd, input logic signed [31:0] e,
                                 input logic signed [31:0] e1, input logic signed [31:0] s);
    exp_t   r;
    longint tot;
    longint scale;
    longint q;
    tot = longint'(gp) * longint'(e) + longint'(gi_) * longint'(s);
`ifdef PID_DERIV_EN
    tot = tot + longint'(gd) * (longint'(e) - longint'(e1));
`else
    if (gd != 0 && e1 != 0) tot = tot + 0;
`endif
    scale = longint'(1) << FRAC;
    q = tot / scale;
    if ((tot % scale) != 0 && tot < 0) q = q - 1;
    if (q > OUT_MAX) begin
      r.u = OUT_MAX; r.s = 1;
    end else if (q < OUT_MIN) begin
      r.u = OUT_MIN; r.s = 1;
    end else begin
      r.u = q; r.s = 0;
    end
    return r;
  endfunction

  task automatic drive(input logic signed [15:0] gp, input logic signed [15:0] gi_,
                       input logic signed [15:0] gd, input logic signed [31:0] e,
                       input logic signed [31:0] e1, input logic signed [31:0] s);
    kp = gp; ki = gi_; kd = gd; error = e; error1 = e1; sum_e = s;
  endtask

  task automatic rand_inputs();
    logic signed [31:0] t;
    kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);
    t = $urandom; error  = t >>> $urandom_range(0, 22);
    t = $urandom; error1 = t >>> $urandom_range(0, 22);
    t = $urandom; sum_e  = t >>> $urandom_range(0, 22);
  endtask

  // One accepted transaction: latency, value, sat flag, pulse width.
  task automatic run_txn(input string tag, input logic signed [15:0] gp, input logic signed [15:0] gi_,
                         input logic signed [15:0] gd, input logic signed [31:0] e,
                         input logic signed [31:0] e1, input logic signed [31:0] s);
    exp_t r;
    int   n;
    r = model(gp, gi_, gd, e, e1, s);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, longint'(in_ready), 1);
    drive(gp, gi_, gd, e, e1, s);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rand_inputs();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_u"}, longint'($signed(u)), r.u);
    chk({tag, "_sat"}, longint'(sat), r.s);
    chk({tag, "_ready_with_valid"}, longint'(in_ready), 1);
    $display("txn %s kp=%0d ki=%0d kd=%0d e=%0d e1=%0d sum=%0d -> u=%0d sat=%0b (exp u=%0d sat=%0d) lat=%0d",
             tag, gp, gi_, gd, e, e1, s, $signed(u), sat, r.u, r.s, n);
    tick();
    chk({tag, "_pulse"}, longint'(out_valid), 0);
  endtask

  initial begin
    exp_t r;
    int   last_acc;
    int   accepts;
    int   n;
    bit   seen;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_u", longint'(u), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);

    // Directed cases
    run_txn("p_only", 256, 0, 0, 1000, 0, 0);
    run_txn("full_pid", 128, 64, 256, 400, 100, 1024);
    run_txn("sat_hi", 256, 0, 0, 200000, 0, 0);
    run_txn("sat_lo", 256, 0, 0, -200000, 0, 0);
    run_txn("floor", 1, 0, 0, -1, 0, 0);
    run_txn("diff_wide", 0, 0, 256, 32'sh7fffffff, 32'sh80000000, 0);
    run_txn("diff_wide_neg", 0, 0, 256, 32'sh80000000, 32'sh7fffffff, 0);
    run_txn("neg_i", 0, -300, 0, 0, 0, 5000);

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      rand_inputs();
      run_txn($sformatf("rand%0d", i), kp, ki, kd, error, error1, sum_e);
    end

    // Handshake: in_valid held high with fresh data every cycle
    last_acc = -1;
    accepts = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("hs_u", longint'($signed(u)), r.u);
          chk("hs_sat", longint'(sat), r.s);
          $display("txn hs cyc=%0d u=%0d sat=%0b (exp u=%0d sat=%0d)", cyc, $signed(u), sat, r.u, r.s);
        end else begin
          chk("hs_spurious_valid", 1, 0);
        end
      end
      rand_inputs();
      if (in_ready) begin
        exp_q.push_back(model(kp, ki, kd, error, error1, sum_e));
        if (last_acc >= 0) chk("hs_interval", cyc - last_acc, LAT + 1);
        last_acc = cyc;
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 12) begin
      if (out_valid) begin
        r = exp_q.pop_front();
        chk("hs_drain_u", longint'($signed(u)), r.u);
        chk("hs_drain_sat", longint'(sat), r.s);
        $display("txn hs_drain u=%0d sat=%0b (exp u=%0d sat=%0d)", $signed(u), sat, r.u, r.s);
      end
      tick();
      n++;
    end
    chk("hs_pending", exp_q.size(), 0);
    chk("hs_accepts", accepts, (40 + LAT) / (LAT + 1));
    repeat (2) tick();

    // Reset in the middle of a computation
    drive(256, 0, 0, 1000, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_valid", longint'(seen), 0);
    chk("midrst_u", longint'(u), 0);
    chk("midrst_sat", longint'(sat), 0);
    $display("txn midrst u=%0d seen_valid=%0b", $signed(u), seen);

    // Block still functional after the aborted computation
    run_txn("after_rst", 256, 0, 0, -1234, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pid_calc.md
# pid_calc

Computes the PID control output from the error triplet (current error, previous error, error integral) produced by the error-conditioning stage. Uses one shared signed multiplier over a small FSM, applies fixed-point scaling, and saturates the result. Sits between the error stage and the actuator driver (PWM/DAC) in the closed-loop path.

## Interface
- `FRAC`, 8: fractional bits of `kp`/`ki`/`kd` (Q7.8 by default).
- `OUT_MAX`, 100000: signed upper output limit.
- `OUT_MIN`, -100000: signed lower output limit.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  error triplet and gains valid.
- `in_ready`  out  1  block idle and able to accept.
- `error`  in  32  signed current error e(k).
- `error1`  in  32  signed previous error e(k-1).
- `sum_e`  in  32  signed error integral.
- `kp`, `ki`, `kd`  in  16 each  signed gains, Q(15-FRAC).FRAC.
- `u`  out  32  signed control output; held between results.
- `out_valid`  out  1  one-cycle pulse when `u` updates.
- `sat`  out  1  last result clipped; updates with `u`.

## Operation
- FSM states: IDLE, MUL_P, MUL_I, MUL_D, SAT.
- `in_ready` = (state == IDLE), combinational from the state register.
- IDLE: on `in_valid && in_ready`, register all six inputs, clear the accumulator, go to MUL_P. Inputs are not sampled in any other state.
- MUL_P: acc <= kp*e_r, go to MUL_I.
- MUL_I: acc <= acc + ki*sum_r, go to MUL_D.
- MUL_D: diff = e_r - e1_r computed at 33 bits (no wrap); acc <= acc + kd*diff, go to SAT.
- SAT: y = acc >>> FRAC (arithmetic shift, floor rounding). If y > OUT_MAX then u <= OUT_MAX, sat <= 1; if y < OUT_MIN then u <= OUT_MIN, sat <= 1; otherwise u <= y[31:0], sat <= 0. Pulse `out_valid`, return to IDLE.
- Accumulator is 52-bit signed; products sign-extended. No intermediate overflow for any input combination.
- One multiplier instance (16x33 signed), operands muxed by state.
- Reset: state IDLE, acc 0, `u` 0, `sat` 0, `out_valid` 0, registered inputs 0. Reset mid-computation aborts the computation; no `out_valid` is produced for it.

## Timing
- Accept at edge E0. MUL_P, MUL_I, MUL_D and SAT execute on E1..E4. `u`, `sat` and `out_valid` become visible after E4.
- Latency: 4 cycles from accept to `out_valid`. Initiation interval: 5 cycles.
- `in_ready` rises in the same cycle `out_valid` is high. A new triplet may be accepted in that cycle.
- `out_valid` is high for exactly one cycle per accepted triplet. There is no backpressure on the output.
- `in_valid` while busy is ignored, not queued.

## Configuration
- `PID_DERIV_EN` defined: derivative term included. FSM runs MUL_P→MUL_I→MUL_D→SAT; latency 4, interval 5.
- `PID_DERIV_EN` undefined: MUL_D state and the `diff` path are removed. MUL_I goes directly to SAT; latency 3, interval 4. `kd` and `error1` are accepted but ignored.

## Test plan
- Reset and P-only: assert `rst`, then check `u`=0, `sat`=0, `out_valid`=0, `in_ready`=1. Then apply kp=256, ki=0, kd=0, error=1000 → u=1000, sat=0, `out_valid` exactly 4 cycles after accept.
- Full PID: kp=128, ki=64, kd=256, error=400, error1=100, sum_e=1024 → u=756 (P 200 + I 256 + D 300). Without `PID_DERIV_EN` → u=456 after 3 cycles.
- Saturation: kp=256, error=200000 → u=100000, sat=1. Same with error=-200000 → u=-100000, sat=1.
- Rounding and width: kp=1, error=-1 → u=-1 (floor). kd=256, error=2147483647, error1=-2147483648 → u=OUT_MAX, sat=1, with no wrap in `diff`.
- Handshake: hold `in_valid` high continuously with changing data. Check one accept every 5 cycles, that each `u` matches the triplet present at its accept edge, and that mid-busy data is ignored.
- Reset mid-op: accept a triplet, then assert `rst` at E2 → no `out_valid`, `u` stays 0, `in_ready`=1 the cycle after reset is released.
